// File: rtl/renaming_reg_file_pkg.sv
// Shared types and defaults for the renaming register file and its
// checkpoint store. The rename entry carries the package-wide tag width,
// so a non-default ROB id width is changed here, alongside ROB_W.
// Optional trace build: define RF_COMMIT_TRACE_EN.
package renaming_reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ROB_W_DEF = 4;
    localparam int NREG_DEF  = 32;
    localparam int RIDX_DEF  = $clog2(NREG_DEF);

    typedef logic [RIDX_DEF-1:0] reg_id_t;

    localparam reg_id_t REG_ZERO = '0;

    typedef struct packed {
        logic                 busy;
        logic [ROB_W_DEF-1:0] tag;
    } rename_entry_t;

    // True when a retiring ROB id matches the newest writer recorded in an entry.
    function automatic logic tag_retires(rename_entry_t e, logic [ROB_W_DEF-1:0] rob);
        return e.tag == rob;
    endfunction

endpackage

// File: rtl/rf_ckpt_store.sv
// Branch checkpoint store: a circular buffer of rename-table snapshots
// managed by head/tail/count. Snapshots keep retiring tags cleared so a
// restore never brings back a writer that has already committed.
// Optional trace build: define RF_COMMIT_TRACE_EN (prints each restore).
module rf_ckpt_store
    import renaming_reg_file_pkg::*;
#(
    parameter  int NREG       = NREG_DEF,
    parameter  int ROB_W      = ROB_W_DEF,
    parameter  int CKPT_DEPTH = 4,
    localparam int RIDX       = $clog2(NREG),
    localparam int CK_W       = $clog2(CKPT_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rdy_i,
    input  logic                flush_i,
    input  logic                take_i,
    input  logic                release_i,
    input  logic                restore_i,
    input  logic [CK_W-1:0]     restore_id_i,
    input  logic                commit_valid_i,
    input  logic [RIDX-1:0]     commit_reg_i,
    input  logic [ROB_W-1:0]    commit_rob_i,
    input  rename_entry_t       snap_tbl_i    [NREG],
    output rename_entry_t       restore_tbl_o [NREG],
    output logic [CK_W-1:0]     ckpt_id_o,
    output logic                ckpt_full_o
);

    localparam logic [CK_W:0] DEPTH_C = (CK_W+1)'(CKPT_DEPTH);

    rename_entry_t   slot_q [CKPT_DEPTH][NREG];
    logic [CK_W-1:0] head_q, head_d;
    logic [CK_W-1:0] tail_q, tail_d;
    logic [CK_W:0]   count_q, count_d;
    logic            full_q;

    logic            clr_en;
    logic            rel_ok;
    logic            take_ok;

    assign clr_en  = rdy_i && commit_valid_i && (commit_reg_i != REG_ZERO);
    assign rel_ok  = release_i && (count_q != '0);
    // A release in the same cycle frees the oldest slot, so a take still fits.
    assign take_ok = take_i && (!full_q || rel_ok) && !restore_i;

    // Restore source: the selected snapshot with this cycle's retirement applied.
    always_comb begin
        restore_tbl_o = slot_q[restore_id_i];
        if (clr_en && tag_retires(restore_tbl_o[commit_reg_i], commit_rob_i)) begin
            restore_tbl_o[commit_reg_i].busy = 1'b0;
        end
    end

    // Next head/tail/count; flush beats restore, restore beats take.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_i) begin
            if (flush_i) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else if (restore_i) begin
                head_d  = head_q + CK_W'(rel_ok);
                tail_d  = restore_id_i;
                count_d = {1'b0, restore_id_i - head_d};
            end else begin
                head_d  = head_q + CK_W'(rel_ok);
                tail_d  = tail_q + CK_W'(take_ok);
                count_d = count_q + (CK_W+1)'(take_ok) - (CK_W+1)'(rel_ok);
            end
        end
    end

    // Pointer state and registered full flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // Snapshot storage: capture at the tail on take, else retire matching tags.
    always_ff @(posedge clk_i) begin
        if (rdy_i && !flush_i) begin
            for (int s = 0; s < CKPT_DEPTH; s++) begin
                if (take_ok && (CK_W'(s) == tail_q)) begin
                    slot_q[s] <= snap_tbl_i;
                end else if (clr_en && tag_retires(slot_q[s][commit_reg_i], commit_rob_i)) begin
                    slot_q[s][commit_reg_i].busy <= 1'b0;
                end
            end
        end
    end

    assign ckpt_id_o   = tail_q;
    assign ckpt_full_o = full_q;

`ifdef RF_COMMIT_TRACE_EN
    // Report each accepted restore together with the resulting live count.
    always_ff @(posedge clk_i) begin
        if (rdy_i && !flush_i && restore_i) begin
            $display("rf_ckpt_store: restore id %0d count %0d", restore_id_i, count_d);
        end
    end
`else
    // Trace build disabled: no reporting logic.
`endif

endmodule

// File: rtl/renaming_reg_file.sv
// Renaming register file: architectural values plus a per-register rename
// tag (newest in-flight ROB writer), RD_PORTS forwarding read ports and
// branch checkpoints held in rf_ckpt_store.
// Optional trace build: define RF_COMMIT_TRACE_EN (commit/restore prints and
// a shadow copy of the architectural values).
module renaming_reg_file
    import renaming_reg_file_pkg::*;
#(
    parameter  int XLEN       = XLEN_DEF,
    parameter  int NREG       = NREG_DEF,
    parameter  int ROB_W      = ROB_W_DEF,
    parameter  int RD_PORTS   = 2,
    parameter  int CKPT_DEPTH = 4,
    localparam int RIDX       = $clog2(NREG),
    localparam int CK_W       = $clog2(CKPT_DEPTH)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush_all_in,
    input  logic                      commit_valid_in,
    input  logic [RIDX-1:0]           commit_reg_in,
    input  logic [XLEN-1:0]           commit_val_in,
    input  logic [ROB_W-1:0]          commit_rob_in,
    input  logic                      rename_valid_in,
    input  logic [RIDX-1:0]           rename_reg_in,
    input  logic [ROB_W-1:0]          rename_rob_in,
    input  logic [RD_PORTS*RIDX-1:0]  rd_id_in,
    output logic [RD_PORTS*XLEN-1:0]  rd_val_out,
    output logic [RD_PORTS-1:0]       rd_busy_out,
    output logic [RD_PORTS*ROB_W-1:0] rd_tag_out,
    output logic [RD_PORTS*ROB_W-1:0] rob_q_tag_out,
    input  logic [RD_PORTS-1:0]       rob_q_ready_in,
    input  logic [RD_PORTS*XLEN-1:0]  rob_q_val_in,
    input  logic                      ckpt_take_in,
    output logic [CK_W-1:0]           ckpt_id_out,
    output logic                      ckpt_full_out,
    input  logic                      ckpt_release_in,
    input  logic                      ckpt_restore_in,
    input  logic [CK_W-1:0]           ckpt_restore_id_in
);

    logic [XLEN-1:0] regs_q   [NREG];
    rename_entry_t   table_q  [NREG];
    rename_entry_t   table_d  [NREG];
    rename_entry_t   post_tbl [NREG];
    rename_entry_t   rest_tbl [NREG];

    logic commit_wr;
    logic rename_wr;

    assign commit_wr = rdy_in && commit_valid_in && (commit_reg_in != REG_ZERO);
    assign rename_wr = rdy_in && rename_valid_in && (rename_reg_in != REG_ZERO);

    // Live table after this cycle's commit clear and rename (rename wins).
    always_comb begin
        post_tbl = table_q;
        if (commit_wr && tag_retires(table_q[commit_reg_in], commit_rob_in)
            && !(rename_wr && (rename_reg_in == commit_reg_in))) begin
            post_tbl[commit_reg_in].busy = 1'b0;
        end
        if (rename_wr) begin
            post_tbl[rename_reg_in].busy = 1'b1;
            post_tbl[rename_reg_in].tag  = rename_rob_in;
        end
    end

    // Next live table: flush clears everything, restore reloads a snapshot.
    always_comb begin
        table_d = table_q;
        if (rdy_in) begin
            if (flush_all_in) begin
                for (int i = 0; i < NREG; i++) begin
                    table_d[i] = '0;
                end
            end else if (ckpt_restore_in) begin
                table_d = rest_tbl;
            end else begin
                table_d = post_tbl;
            end
        end
    end

    // Rename table state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREG; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Architectural values; a commit write lands even during flush or restore.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_wr) begin
            regs_q[commit_reg_in] <= commit_val_in;
        end
    end

    // Read ports: same-cycle rename, then settled value, then commit bypass, then ROB.
    always_comb begin
        logic [RIDX-1:0] rid;
        rename_entry_t   ent;
        rd_val_out    = '0;
        rd_busy_out   = '0;
        rd_tag_out    = '0;
        rob_q_tag_out = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rid = rd_id_in[p*RIDX +: RIDX];
            ent = table_q[rid];
            rob_q_tag_out[p*ROB_W +: ROB_W] = ent.tag;
            rd_tag_out[p*ROB_W +: ROB_W]    = ent.tag;
            if (rename_valid_in && (rename_reg_in == rid) && (rid != REG_ZERO)) begin
                rd_busy_out[p]               = 1'b1;
                rd_tag_out[p*ROB_W +: ROB_W] = rename_rob_in;
                rd_val_out[p*XLEN +: XLEN]   = regs_q[rid];
            end else if (!ent.busy) begin
                rd_busy_out[p]             = 1'b0;
                rd_val_out[p*XLEN +: XLEN] = regs_q[rid];
            end else if (commit_valid_in && (commit_reg_in == rid)
                         && tag_retires(ent, commit_rob_in)) begin
                rd_busy_out[p]             = 1'b0;
                rd_val_out[p*XLEN +: XLEN] = commit_val_in;
            end else begin
                rd_busy_out[p]             = !rob_q_ready_in[p];
                rd_val_out[p*XLEN +: XLEN] = rob_q_val_in[p*XLEN +: XLEN];
            end
        end
    end

    rf_ckpt_store #(
        .NREG       (NREG),
        .ROB_W      (ROB_W),
        .CKPT_DEPTH (CKPT_DEPTH)
    ) u_ckpt (
        .clk_i          (clk_in),
        .rst_ni         (rst_n_in),
        .rdy_i          (rdy_in),
        .flush_i        (flush_all_in),
        .take_i         (ckpt_take_in),
        .release_i      (ckpt_release_in),
        .restore_i      (ckpt_restore_in),
        .restore_id_i   (ckpt_restore_id_in),
        .commit_valid_i (commit_valid_in),
        .commit_reg_i   (commit_reg_in),
        .commit_rob_i   (commit_rob_in),
        .snap_tbl_i     (post_tbl),
        .restore_tbl_o  (rest_tbl),
        .ckpt_id_o      (ckpt_id_out),
        .ckpt_full_o    (ckpt_full_out)
    );

`ifdef RF_COMMIT_TRACE_EN
    logic [XLEN-1:0] shadow_q [NREG];

    // Sim-only mirror of architectural values plus a commit log.
    always_ff @(posedge clk_in) begin
        if (commit_wr) begin
            shadow_q[commit_reg_in] <= commit_val_in;
            $display("renaming_reg_file: commit x%0d = 0x%0h rob %0d",
                     commit_reg_in, commit_val_in, commit_rob_in);
        end
    end
`else
    // Trace build disabled: no shadow copy or reporting logic.
`endif

endmodule

// File: tb/tb_renaming_reg_file.sv
// Randomised scoreboard bench for renaming_reg_file: a spec-level model
// (arrays plus a queue of live snapshots) predicts each cycle's outputs,
// pushes them to a queue, and a negedge monitor pops and compares.
module tb_renaming_reg_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int ROB_W = 4;
    localparam int RDP = 2;
    localparam int RIDX = 5;
    localparam int CK_W = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus
    logic             rdy, flush, cv, rv, take, rel, restore;
    logic [RIDX-1:0]  creg, rreg;
    logic [XLEN-1:0]  cval;
    logic [ROB_W-1:0] crob, rrob;
    logic [CK_W-1:0]  rid;
    logic [RIDX-1:0]  rd_id [RDP];
    logic [RDP-1:0]   rqr;
    logic [XLEN-1:0]  rqv [RDP];

    logic [RDP*RIDX-1:0]  rd_id_flat;
    logic [RDP*XLEN-1:0]  rqv_flat;
    logic [RDP*XLEN-1:0]  rd_val;
    logic [RDP-1:0]       rd_busy;
    logic [RDP*ROB_W-1:0] rd_tag, rq_tag;
    logic [CK_W-1:0]      ck_id;
    logic                 ck_full;

    assign rd_id_flat = {rd_id[1], rd_id[0]};
    assign rqv_flat   = {rqv[1], rqv[0]};

    renaming_reg_file dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .rdy_in             (rdy),
        .flush_all_in       (flush),
        .commit_valid_in    (cv),
        .commit_reg_in      (creg),
        .commit_val_in      (cval),
        .commit_rob_in      (crob),
        .rename_valid_in    (rv),
        .rename_reg_in      (rreg),
        .rename_rob_in      (rrob),
        .rd_id_in           (rd_id_flat),
        .rd_val_out         (rd_val),
        .rd_busy_out        (rd_busy),
        .rd_tag_out         (rd_tag),
        .rob_q_tag_out      (rq_tag),
        .rob_q_ready_in     (rqr),
        .rob_q_val_in       (rqv_flat),
        .ckpt_take_in       (take),
        .ckpt_id_out        (ck_id),
        .ckpt_full_out      (ck_full),
        .ckpt_release_in    (rel),
        .ckpt_restore_in    (restore),
        .ckpt_restore_id_in (rid)
    );

    // reference model
    typedef struct packed {
        logic [NREG-1:0]       busy;
        logic [NREG*ROB_W-1:0] tags;
    } snap_t;

    logic [XLEN-1:0]  mregs [NREG];
    logic [NREG-1:0]  mbusy;
    logic [ROB_W-1:0] mtag [NREG];
    snap_t            ckq [$];
    int               mhead;

    typedef struct packed {
        logic [RDP*XLEN-1:0]  val;
        logic [RDP-1:0]       busy;
        logic [RDP*ROB_W-1:0] tag;
        logic [RDP*ROB_W-1:0] rqtag;
        logic [CK_W-1:0]      ckid;
        logic                 full;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic snap_t take_snap();
        snap_t s;
        s.busy = mbusy;
        for (int i = 0; i < NREG; i++) s.tags[i*ROB_W +: ROB_W] = mtag[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = '0;
            mtag[i]  = '0;
        end
        mbusy = '0;
        ckq.delete();
        mhead = 0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        for (int p = 0; p < RDP; p++) begin
            int id;
            id = int'(rd_id[p]);
            e.rqtag[p*ROB_W +: ROB_W] = mtag[id];
            e.tag[p*ROB_W +: ROB_W]   = mtag[id];
            if (rv && rreg == rd_id[p] && id != 0) begin
                e.busy[p] = 1'b1;
                e.tag[p*ROB_W +: ROB_W] = rrob;
            end else if (!mbusy[id]) begin
                e.val[p*XLEN +: XLEN] = mregs[id];
            end else if (cv && creg == rd_id[p] && crob == mtag[id]) begin
                e.val[p*XLEN +: XLEN] = cval;
            end else begin
                e.busy[p] = !rqr[p];
                e.val[p*XLEN +: XLEN] = rqv[p];
            end
        end
        e.ckid = CK_W'((mhead + ckq.size()) % DEPTH);
        e.full = (ckq.size() == DEPTH);
        return e;
    endfunction

    task automatic model_step();
        snap_t s;
        int pos;
        if (!rdy) return;
        if (cv && creg != 0) mregs[creg] = cval;
        if (flush) begin
            mbusy = '0;
            for (int i = 0; i < NREG; i++) mtag[i] = '0;
            ckq.delete();
            mhead = 0;
            return;
        end
        if (cv && creg != 0) begin
            for (int i = 0; i < ckq.size(); i++) begin
                s = ckq[i];
                if (s.tags[int'(creg)*ROB_W +: ROB_W] == crob) s.busy[creg] = 1'b0;
                ckq[i] = s;
            end
        end
        if (restore) begin
            if (rel && ckq.size() > 0) begin
                void'(ckq.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            pos = (int'(rid) - mhead + DEPTH) % DEPTH;
            s = ckq[pos];
            mbusy = s.busy;
            for (int i = 0; i < NREG; i++) mtag[i] = s.tags[i*ROB_W +: ROB_W];
            while (ckq.size() > pos) void'(ckq.pop_back());
        end else begin
            if (cv && creg != 0 && mtag[creg] == crob && !(rv && rreg == creg)) mbusy[creg] = 1'b0;
            if (rv && rreg != 0) begin
                mbusy[rreg] = 1'b1;
                mtag[rreg]  = rrob;
            end
            if (rel && ckq.size() > 0) begin
                void'(ckq.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            if (take && ckq.size() < DEPTH) ckq.push_back(take_snap());
        end
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; cv = 1'b0; rv = 1'b0;
        take = 1'b0; rel = 1'b0; restore = 1'b0;
        creg = '0; rreg = '0; cval = '0; crob = '0; rrob = '0; rid = '0;
        rqr = '0;
        for (int p = 0; p < RDP; p++) begin
            rd_id[p] = '0;
            rqv[p]   = '0;
        end
    endtask

    // One cycle: predict, queue, clock, advance the model.
    task automatic step();
        exp_q.push_back(predict());
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: combinational outputs are compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < RDP; p++) begin
                chk($sformatf("rd%0d_busy", p), 32'(rd_busy[p]), 32'(e.busy[p]));
                chk($sformatf("rd%0d_tag", p), 32'(rd_tag[p*ROB_W +: ROB_W]), 32'(e.tag[p*ROB_W +: ROB_W]));
                chk($sformatf("rob_q%0d_tag", p), 32'(rq_tag[p*ROB_W +: ROB_W]), 32'(e.rqtag[p*ROB_W +: ROB_W]));
                if (!e.busy[p]) chk($sformatf("rd%0d_val", p), rd_val[p*XLEN +: XLEN], e.val[p*XLEN +: XLEN]);
            end
            chk("ckpt_id", 32'(ck_id), 32'(e.ckid));
            chk("ckpt_full", 32'(ck_full), 32'(e.full));
        end
    end

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state, random read ids
        rd_id[0] = 5'd5; rd_id[1] = 5'd31; step();
        idle(); step();

        // commit without prior rename
        idle(); cv = 1; creg = 5; cval = 32'h1234; crob = 0; step();
        idle(); rd_id[0] = 5; step();

        // rename, ROB forward, commit
        idle(); rv = 1; rreg = 3; rrob = 7; rd_id[0] = 3; rd_id[1] = 3; step();
        idle(); rd_id[0] = 3; rqr[0] = 1; rqv[0] = 32'hAA; rd_id[1] = 3; step();
        idle(); cv = 1; creg = 3; cval = 32'hAA; crob = 7; rd_id[0] = 3; step();
        idle(); rd_id[0] = 3; step();

        // older commit does not clear a newer rename
        idle(); rv = 1; rreg = 4; rrob = 2; step();
        idle(); rv = 1; rreg = 4; rrob = 5; step();
        idle(); cv = 1; creg = 4; crob = 2; cval = 32'h44; rd_id[0] = 4; step();
        idle(); rd_id[0] = 4; rd_id[1] = 4; step();

        // checkpoint, commit retires snapshot tag, restore
        idle(); rv = 1; rreg = 6; rrob = 1; step();
        idle(); take = 1; step();
        idle(); rv = 1; rreg = 6; rrob = 3; step();
        idle(); cv = 1; creg = 6; crob = 1; cval = 32'h66; rd_id[0] = 6; step();
        idle(); restore = 1; rid = 0; rd_id[0] = 6; step();
        idle(); rd_id[0] = 6; step();

        // fill, overfill, take+release at full, drain
        for (int i = 0; i < 5; i++) begin idle(); take = 1; step(); end
        idle(); take = 1; rel = 1; step();
        for (int i = 0; i < 4; i++) begin idle(); rel = 1; step(); end
        idle(); rel = 1; step();

        // flush with commit and rename to x9
        idle(); take = 1; rv = 1; rreg = 9; rrob = 8; step();
        idle(); take = 1; step();
        idle(); flush = 1; cv = 1; creg = 9; cval = 32'h55; crob = 3;
        rv = 1; rreg = 9; rrob = 3; take = 1; rel = 1; rd_id[0] = 9; step();
        idle(); rd_id[0] = 9; step();

        // x0 ignores rename and commit
        idle(); rv = 1; rreg = 0; rrob = 5; cv = 1; creg = 0; cval = 32'hFF; rd_id[0] = 0; step();
        idle(); rd_id[1] = 0; step();

        // hold: rdy low
        idle(); rdy = 0; rv = 1; rreg = 2; rrob = 9; take = 1; cv = 1; creg = 2; cval = 32'h22; step();
        idle(); rd_id[0] = 2; step();

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            cv    = $urandom_range(0, 1);
            creg  = RIDX'($urandom_range(0, 7));
            cval  = $urandom;
            crob  = ($urandom_range(0, 2) != 0) ? mtag[creg] : ROB_W'($urandom);
            rv    = $urandom_range(0, 1);
            rreg  = RIDX'($urandom_range(0, 7));
            rrob  = ROB_W'($urandom);
            for (int p = 0; p < RDP; p++) begin
                rd_id[p] = RIDX'($urandom_range(0, 7));
                rqv[p]   = $urandom;
            end
            rqr  = RDP'($urandom);
            take = ($urandom_range(0, 2) == 0);
            rel  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0 && ckq.size() > (rel ? 1 : 0)) begin
                int pos;
                pos = $urandom_range(rel ? 1 : 0, ckq.size() - 1);
                rid = CK_W'((mhead + pos) % DEPTH);
                restore = 1'b1;
            end
            step();
        end

        idle();
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/renaming_reg_file.md
Name: renaming_reg_file

Overview:
- Parametrised successor of the renaming register file; sits between decode/issue and the reorder buffer (ROB).
- Holds the architectural values and a per-register rename tag (the ROB id of the newest in-flight writer).
- Has N read ports, each with ROB forwarding.
- Adds branch checkpoints: on a mispredict the rename table is restored from a snapshot instead of being cleared wholesale.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count (power of 2); RIDX=$clog2(NREG).
- ROB_W, 4, ROB id width.
- RD_PORTS, 2, number of read ports.
- CKPT_DEPTH, 4, number of checkpoint slots (power of 2); CK_W=$clog2(CKPT_DEPTH).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  low = hold all state.
- flush_all_in  in  1  clear all tags and checkpoints.
- commit_valid_in  in  1  ROB retires a write.
- commit_reg_in  in  RIDX  destination register.
- commit_val_in  in  XLEN  value to write.
- commit_rob_in  in  ROB_W  retiring ROB id.
- rename_valid_in  in  1  decode allocates a new writer.
- rename_reg_in  in  RIDX  register being renamed.
- rename_rob_in  in  ROB_W  new writer's ROB id.
- rd_id_in  in  RD_PORTS*RIDX  read register ids.
- rd_val_out  out  RD_PORTS*XLEN  read values.
- rd_busy_out  out  RD_PORTS  operand not yet available.
- rd_tag_out  out  RD_PORTS*ROB_W  producer ROB id.
- rob_q_tag_out  out  RD_PORTS*ROB_W  ROB lookup tag.
- rob_q_ready_in  in  RD_PORTS  ROB result ready.
- rob_q_val_in  in  RD_PORTS*XLEN  ROB result value.
- ckpt_take_in  in  1  snapshot the rename table.
- ckpt_id_out  out  CK_W  slot the next take will use (the tail).
- ckpt_full_out  out  1  all slots in use.
- ckpt_release_in  in  1  free the oldest slot (branch resolved correct).
- ckpt_restore_in  in  1  mispredict: restore the table from a slot.
- ckpt_restore_id_in  in  CK_W  slot to restore.

Behaviour:
- Reset (async, rst_n_in=0):
  - All regs, tags and busy bits are 0.
  - head=tail=count=0, so ckpt_id_out=0 and ckpt_full_out=0.
  - Read outputs are combinational; with all rd_id=0 they read val=0, busy=0, tag=0.
- rdy_in=0: no state changes; combinational outputs remain valid.
- Register 0: hardwired zero, never busy. Rename or commit to 0 is ignored.
- Read port p, combinational, in priority order:
  1. Same-cycle rename to the same id (id≠0): busy=1, tag=rename_rob_in, val don't-care.
  2. Otherwise, if not busy[id]: val=regs[id], busy=0.
  3. Otherwise, busy[id] and commit_valid && commit_reg==id && commit_rob==tag[id]: val=commit_val_in, busy=0.
  4. Otherwise, busy[id]: val=rob_q_val_in[p], busy=!rob_q_ready_in[p].
  - rob_q_tag_out[p]=tag[id]; rd_tag_out[p] is the tag from rule 1 if it applies, else tag[id].
- Commit (posedge):
  - Write regs[reg]=val.
  - Clear busy only if tag[reg]==commit_rob and no same-cycle rename of reg.
  - Apply the same tag-match clear to every live checkpoint slot, so snapshots never resurrect a retired tag.
- Rename (posedge): tag[reg]=rob, busy[reg]=1. Rename overrides a same-cycle commit clear.
- ckpt_take (ignored when full):
  - slot[tail] captures the table after this cycle's rename and commit.
  - tail++, count++ (wrap modulo CKPT_DEPTH).
- ckpt_release (ignored when count=0): head++, count--.
  - take and release may occur in the same cycle; count is then unchanged.
- ckpt_restore (id must be live):
  - Table = slot[id] with this cycle's commit clear applied.
  - tail=id, count=id-head (mod CKPT_DEPTH); the restored slot and all younger slots are freed.
  - Same-cycle rename and take are dropped. The commit regs write still occurs. Same-cycle release is honoured (head++).
- flush_all (highest priority):
  - All busy bits and tags are 0; head=tail=count=0.
  - The commit regs write still occurs. Rename, take, restore and release are dropped.
- ckpt_full_out = (count==CKPT_DEPTH), registered from state.

Optional Feature:
- RF_COMMIT_TRACE_EN defined:
  - $display on each commit (reg, value, ROB id) and on each restore (id, new count).
  - Adds a sim-only NREG-entry shadow array of architectural values for waveform viewing.
- Undefined: no display statements or shadow logic; RTL is otherwise identical.

Decomposition:
- Shared package holds:
  - XLEN/ROB_W defaults.
  - A rename_entry_t struct {busy, tag}.
  - A register-id type and the REG_ZERO constant.
- One sub-module, rf_ckpt_store:
  - CKPT_DEPTH×NREG rename_entry_t array, head/tail/count, take/release/restore.
  - Per-slot commit-clear logic.
  - The top module keeps regs, the live table and the read ports.

Test Plan:
- Reset, then commit x5=0x1234 rob=0 with no prior rename → next cycle rd x5 val=0x1234, busy=0.
- Rename x3→rob 7; same cycle rd x3 → busy=1, tag=7. Next cycle rob_q_ready=1, val=0xAA → busy=0, val=0xAA. Commit x3 rob 7 → busy clear, regs=0xAA.
- Rename x4→rob 2, then rename x4→rob 5, then commit x4 rob 2 → x4 still busy, tag=5.
- Rename x6→rob 1; take (id 0); rename x6→rob 3; commit x6 rob 1; restore id 0 → x6 not busy, val committed. tail=0, count=0.
- Four takes → ckpt_full_out=1, and a 5th take leaves count at 4. Then take+release in the same cycle → count stays 4, head and tail wrap correctly.
- flush_all with a same-cycle commit x9=0x55 and rename x9 → x9 not busy, regs[9]=0x55, count=0. Rename/commit to x0 → x0 always reads 0, not busy.
